// File: rtl/pea_sched.sv
// pea_sched: PE-array convolution scheduler.
// Walks ic/oc passes over row/column tiles and drives fetch strobes and pvalid.
module pea_sched #(
  parameter int ROWS          = 8,
  parameter int TILE_LEN      = 16,
  parameter int CHN_WIDTH     = 4,
  parameter int CHN_OFT_WIDTH = 6,
  parameter int FMS_WIDTH     = 8,
  parameter int FLUSH_LAT     = 5,
  parameter int PV_LAT        = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 stall,
  input  logic [CHN_WIDTH-1:0] cfg_chi,
  input  logic [CHN_WIDTH-1:0] cfg_cho,
  input  logic                 cfg_stride,
  input  logic                 cfg_k3,
  input  logic [FMS_WIDTH-1:0] cfg_ifm_size,
  output logic [ROWS-1:0]      ifm_read,
  output logic                 wgt_read,
  output logic [ROWS-1:0]      pvalid,
  output logic                 ic_done,
  output logic                 oc_done,
  output logic                 tile_done,
  output logic                 conv_done,
  output logic                 busy
);
  localparam int PCW = $clog2(TILE_LEN);
  localparam int FLW = $clog2(FLUSH_LAT);
  localparam int ICW = CHN_WIDTH + CHN_OFT_WIDTH;
  localparam int FW  = FMS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CALC
  } state_e;

  state_e state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [FLW-1:0] fl_q, fl_d;
  logic [ICW-1:0] ic_q, ic_d;
  logic [ICW-1:0] oc_q, oc_d;
  logic [FW-1:0] ct_q, ct_d;
  logic [FW-1:0] rt_q, rt_d;
  logic [CHN_WIDTH-1:0] chi_q, chi_d;
  logic [CHN_WIDTH-1:0] cho_q, cho_d;
  logic s2_q, s2_d;
  logic k3_q, k3_d;
  logic [FW-1:0] ifm_q, ifm_d;
  logic [PV_LAT-1:0][ROWS-1:0] pv_q, pv_d;

  logic [FW-1:0] ofm, opt_m, rem_cols;
  logic [FW-1:0] rem_rows, ct_last, rt_last;
  logic [ROWS-1:0] row_mask, pv_in;
  logic [PCW-1:0] colx;
  logic last_ct, last_rt, prod, cmask;
  logic in_fl, in_calc, run;
  logic step_last, ic_last, oc_last;

  // Tile geometry from the latched config
  always_comb begin
    ofm = ((ifm_q - (k3_q ? FW'(3) : FW'(1))) >> s2_q)
          + FW'(1);
    opt_m = s2_q ? FW'(TILE_LEN/2 - 1)
                 : FW'(TILE_LEN - 1);
    rem_cols = ofm & opt_m;
    ct_last = (ofm - FW'(1)) >> (s2_q ? PCW-1 : PCW);
    rem_rows = FW'(32'(ofm) % ROWS);
    rt_last = FW'((32'(ofm) - 32'd1) / ROWS);
    last_ct = ct_q == ct_last;
    last_rt = rt_q == rt_last;
    row_mask = (last_rt && rem_rows != '0)
             ? ROWS'((32'd1 << rem_rows) - 32'd1)
             : '1;
    colx = s2_q ? (pc_q >> 1) : pc_q;
    prod = !s2_q || pc_q[0];
    cmask = last_ct && rem_cols != '0
            && FW'(colx) >= rem_cols;
    in_fl = state_q == FLUSH;
    in_calc = state_q == CALC;
    run = !stall && !abort;
    step_last = in_calc
                && pc_q == PCW'(TILE_LEN - 1);
    ic_last = ic_q == {chi_q, {CHN_OFT_WIDTH{1'b0}}}
                      - ICW'(1);
    oc_last = oc_q == {cho_q, {CHN_OFT_WIDTH{1'b0}}}
                      - ICW'(1);
    pv_in = (in_calc && prod && !cmask) ? row_mask : '0;
  end

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fl_d = fl_q;
    ic_d = ic_q;
    oc_d = oc_q;
    ct_d = ct_q;
    rt_d = rt_q;
    chi_d = chi_q;
    cho_d = cho_q;
    s2_d = s2_q;
    k3_d = k3_q;
    ifm_d = ifm_q;
    pv_d = pv_q;
    wgt_read = 1'b0;
    ic_done = 1'b0;
    oc_done = 1'b0;
    tile_done = 1'b0;
    conv_done = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pc_d = '0;
      fl_d = '0;
      ic_d = '0;
      oc_d = '0;
      ct_d = '0;
      rt_d = '0;
      pv_d = '0;
    end else if (!stall) begin
      for (int i = PV_LAT-1; i > 0; i--)
        pv_d[i] = pv_q[i-1];
      pv_d[0] = pv_in;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            chi_d = cfg_chi;
            cho_d = cfg_cho;
            s2_d = cfg_stride;
            k3_d = cfg_k3;
            ifm_d = cfg_ifm_size;
            state_d = FLUSH;
            wgt_read = rstn;
          end
        end
        FLUSH: begin
          wgt_read = fl_q < FLW'(2);
          if (fl_q == FLW'(FLUSH_LAT - 1)) begin
            fl_d = '0;
            state_d = CALC;
          end else begin
            fl_d = fl_q + FLW'(1);
          end
        end
        CALC: begin
          pc_d = pc_q + PCW'(1);
          if (step_last) begin
            pc_d = '0;
            ic_done = 1'b1;
            oc_done = ic_last;
            tile_done = ic_last && oc_last;
            conv_done = tile_done && last_ct && last_rt;
            ic_d = ic_last ? '0 : ic_q + ICW'(1);
            if (oc_done)
              oc_d = oc_last ? '0 : oc_q + ICW'(1);
            if (tile_done) begin
              ct_d = last_ct ? '0 : ct_q + FW'(1);
              if (last_ct)
                rt_d = rt_q + FW'(1);
            end
            if (conv_done) begin
              state_d = IDLE;
              ic_d = '0;
              oc_d = '0;
              ct_d = '0;
              rt_d = '0;
            end else begin
              state_d = FLUSH;
              wgt_read = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ifm_read = (run && (in_fl || in_calc))
                  ? row_mask : '0;
  assign pvalid = run ? pv_q[PV_LAT-1] : '0;
  assign busy = state_q != IDLE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q <= '0;
      fl_q <= '0;
      ic_q <= '0;
      oc_q <= '0;
      ct_q <= '0;
      rt_q <= '0;
      chi_q <= '0;
      cho_q <= '0;
      s2_q <= 1'b0;
      k3_q <= 1'b0;
      ifm_q <= '0;
      pv_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fl_q <= fl_d;
      ic_q <= ic_d;
      oc_q <= oc_d;
      ct_q <= ct_d;
      rt_q <= rt_d;
      chi_q <= chi_d;
      cho_q <= cho_d;
      s2_q <= s2_d;
      k3_q <= k3_d;
      ifm_q <= ifm_d;
      pv_q <= pv_d;
    end
  end
endmodule

// File: tb/tb_pea_sched.sv
// tb_pea_sched: trace-model bench for pea_sched.
// Expected outputs come from an unrolled per-cycle trace of each run.
module tb_pea_sched;
  localparam int ROWS = 8;
  localparam int TL   = 16;
  localparam int CW   = 4;
  localparam int OW   = 1;
  localparam int FW   = 8;
  localparam int FL   = 5;
  localparam int PV   = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  logic [CW-1:0] cfg_chi = 1;
  logic [CW-1:0] cfg_cho = 1;
  logic cfg_stride = 1'b0;
  logic cfg_k3 = 1'b1;
  logic [FW-1:0] cfg_ifm_size = 18;
  logic [ROWS-1:0] ifm_read, pvalid;
  logic wgt_read, ic_done, oc_done;
  logic tile_done, conv_done, busy;

  pea_sched #(
    .ROWS(ROWS), .TILE_LEN(TL), .CHN_WIDTH(CW),
    .CHN_OFT_WIDTH(OW), .FMS_WIDTH(FW),
    .FLUSH_LAT(FL), .PV_LAT(PV)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .abort(abort), .stall(stall),
    .cfg_chi(cfg_chi), .cfg_cho(cfg_cho),
    .cfg_stride(cfg_stride), .cfg_k3(cfg_k3),
    .cfg_ifm_size(cfg_ifm_size),
    .ifm_read(ifm_read), .wgt_read(wgt_read),
    .pvalid(pvalid), .ic_done(ic_done),
    .oc_done(oc_done), .tile_done(tile_done),
    .conv_done(conv_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] ifm;
    logic            wgt;
    logic [ROWS-1:0] pv;
    logic ic, oc, tl, cv, busy;
  } rec_t;

  rec_t exp_q[$];
  logic [ROWS-1:0] hist[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int ic_t[$];
  int conv_t = -1;
  int busy_low_t = -1;
  int pv_cnt = 0;
  int sel_cnt = 0;
  logic [ROWS-1:0] sel_val = '0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void clr_hist();
    hist.delete();
    for (int i = 0; i < PV; i++) hist.push_back('0);
  endfunction

  function automatic void clr_log();
    ic_t.delete();
    conv_t = -1;
    busy_low_t = -1;
    pv_cnt = 0;
    sel_cnt = 0;
  endfunction

  // Unroll a whole run into one record per unstalled cycle.
  function automatic void gen_run(int chi, int cho, int s2,
                                  int k3, int ifm);
    int k = k3 ? 3 : 1;
    int s = s2 ? 2 : 1;
    int ofm = ((ifm - k) / s) + 1;
    int opt = TL / s;
    int nct = (ofm + opt - 1) / opt;
    int nrt = (ofm + ROWS - 1) / ROWS;
    int nic = chi << OW;
    int noc = cho << OW;
    rec_t r;
    r = '0;
    r.wgt = 1'b1;
    exp_q.push_back(r);
    for (int rt = 0; rt < nrt; rt++)
      for (int ct = 0; ct < nct; ct++)
        for (int o = 0; o < noc; o++)
          for (int i = 0; i < nic; i++) begin
            int rows = ofm - rt * ROWS;
            logic [ROWS-1:0] m;
            logic li, lo, lt;
            if (rows > ROWS) rows = ROWS;
            m = ROWS'((1 << rows) - 1);
            li = (i == nic - 1);
            lo = li && (o == noc - 1);
            lt = lo && (ct == nct - 1) && (rt == nrt - 1);
            for (int f = 0; f < FL; f++) begin
              r = '0;
              r.busy = 1'b1;
              r.ifm = m;
              r.wgt = (f < 2);
              exp_q.push_back(r);
            end
            for (int p = 0; p < TL; p++) begin
              r = '0;
              r.busy = 1'b1;
              r.ifm = m;
              if ((p % s) == s - 1 && ct * opt + p / s < ofm)
                r.pv = m;
              if (p == TL - 1) begin
                r.ic = 1'b1;
                r.oc = li;
                r.tl = lo;
                r.cv = lt;
                r.wgt = !lt;
              end
              exp_q.push_back(r);
            end
          end
  endfunction

  always @(negedge clk) begin : cmp
    rec_t e;
    logic [ROWS-1:0] epv;
    e = '0;
    epv = '0;
    if (!rstn) begin
      exp_q.delete();
      clr_hist();
    end else if (abort) begin
      e.busy = (exp_q.size() != 0);
      exp_q.delete();
      clr_hist();
    end else if (stall) begin
      e.busy = (exp_q.size() != 0);
    end else begin
      if (exp_q.size() == 0 && start)
        gen_run(int'(cfg_chi), int'(cfg_cho), int'(cfg_stride),
                int'(cfg_k3), int'(cfg_ifm_size));
      if (exp_q.size() != 0) e = exp_q.pop_front();
      epv = hist.pop_front();
      hist.push_back(e.pv);
    end
    chk("ifm_read", 32'(ifm_read), 32'(e.ifm));
    chk("wgt_read", 32'(wgt_read), 32'(e.wgt));
    chk("pvalid", 32'(pvalid), 32'(epv));
    chk("ic_done", 32'(ic_done), 32'(e.ic));
    chk("oc_done", 32'(oc_done), 32'(e.oc));
    chk("tile_done", 32'(tile_done), 32'(e.tl));
    chk("conv_done", 32'(conv_done), 32'(e.cv));
    chk("busy", 32'(busy), 32'(e.busy));
    if (ic_done === 1'b1) ic_t.push_back(cyc - t0);
    if (conv_done === 1'b1) conv_t = cyc - t0;
    if (prev_busy && busy === 1'b0) busy_low_t = cyc - t0;
    if (pvalid !== '0) pv_cnt++;
    if (pvalid === sel_val) sel_cnt++;
    prev_busy = busy;
  end

  task automatic do_start(int chi, int cho, int s2,
                          int k3, int ifm);
    cfg_chi = CW'(chi);
    cfg_cho = CW'(cho);
    cfg_stride = 1'(s2);
    cfg_k3 = 1'(k3);
    cfg_ifm_size = FW'(ifm);
    start = 1'b1;
    t0 = cyc;
    clr_log();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_to_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("run_timeout", 32'(n < budget), 32'd1);
    repeat (PV + 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(int rel);
    while (cyc < t0 + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_base_timing(string tag, int stall_at);
    chk({tag, "_ic_cnt"}, 32'(ic_t.size()), 32'd8);
    for (int n = 0; n < 8; n++)
      if (n < ic_t.size())
        chk($sformatf("%s_ic%0d", tag, n), 32'(ic_t[n]),
            32'(21 * (n + 1) + ((21 * (n + 1) > stall_at) ? 4 : 0)));
    chk({tag, "_conv"}, 32'(conv_t),
        32'(168 + ((168 > stall_at) ? 4 : 0)));
    chk({tag, "_busy_low"}, 32'(busy_low_t),
        32'(169 + ((169 > stall_at) ? 4 : 0)));
  endtask

  task automatic rand_run();
    int k3 = $urandom_range(0, 1);
    int n = 0;
    do_start($urandom_range(1, 2), $urandom_range(1, 2),
             $urandom_range(0, 1), k3,
             $urandom_range(k3 ? 3 : 1, 20));
    while (busy && n < 6000) begin
      stall = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 1499) == 0);
      cfg_ifm_size = FW'($urandom_range(1, 40));
      cfg_k3 = 1'($urandom_range(0, 1));
      cfg_chi = CW'($urandom_range(1, 15));
      @(posedge clk);
      #1;
      n++;
    end
    stall = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    chk("rand_timeout", 32'(n < 6000), 32'd1);
    repeat (PV + 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ifm", 32'(ifm_read), 32'd0);
    chk("rst_pv", 32'(pvalid), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 18x18 3x3 stride 1: 8 passes of 21 cycles
    do_start(1, 1, 0, 1, 18);
    run_to_idle(400);
    chk_base_timing("base", 1 << 30);

    // ofm 11: partial column and row tile
    sel_val = 8'h07;
    do_start(1, 1, 0, 1, 13);
    run_to_idle(400);
    chk("k13_pv_cnt", 32'(pv_cnt), 32'd88);
    chk("k13_pv_07", 32'(sel_cnt), 32'd44);

    // ofm 9 stride 2: two column tiles
    sel_val = 8'h01;
    do_start(1, 1, 1, 1, 19);
    run_to_idle(800);
    chk("s2_pv_cnt", 32'(pv_cnt), 32'd72);
    chk("s2_pv_01", 32'(sel_cnt), 32'd36);

    // 4-cycle stall inside the third CALC phase
    do_start(1, 1, 0, 1, 18);
    wait_to(50);
    stall = 1'b1;
    #1;
    chk("stall_ifm", 32'(ifm_read), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    run_to_idle(400);
    chk_base_timing("stall", 50);

    // abort mid-CALC, restart after one idle cycle
    do_start(1, 1, 0, 1, 18);
    wait_to(30);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ifm", 32'(ifm_read), 32'd0);
    do_start(1, 1, 0, 1, 18);
    run_to_idle(400);
    chk_base_timing("restart", 1 << 30);

    // asynchronous reset during FLUSH
    do_start(2, 1, 0, 1, 18);
    #1;
    chk("pre_rst_ifm", 32'(ifm_read), 32'hff);
    rstn = 1'b0;
    #1;
    chk("arst_ifm", 32'(ifm_read), 32'd0);
    chk("arst_wgt", 32'(wgt_read), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pv", 32'(pvalid), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("arst_no_done", 32'(ic_t.size()), 32'd0);

    for (int r = 0; r < 10; r++) rand_run();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/pea_sched.md
PEA_SCHED -- requirements
Module: pea_sched

Interface
REQ-001 Parameter ROWS, default 8: PE rows; width of per-row outputs.
REQ-002 Parameter TILE_LEN, default 16: counted steps per input-channel pass (power of two).
REQ-003 Parameter CHN_WIDTH, default 4: width of channel-group configuration.
REQ-004 Parameter CHN_OFT_WIDTH, default 6: log2 channels per group.
REQ-005 Parameter FMS_WIDTH, default 8: feature-map size width.
REQ-006 Parameter FLUSH_LAT, default 5: FLUSH state length in cycles (at least 3).
REQ-007 Parameter PV_LAT, default 3: step-to-pvalid delay in cycles.
REQ-008 clk  in  1  clock, rising edge.
REQ-009 rstn  in  1  reset, asynchronous, active-low.
REQ-010 start  in  1  one-cycle start pulse, accepted only in IDLE.
REQ-011 abort  in  1  synchronous abort.
REQ-012 stall  in  1  backpressure, freezes scheduling.
REQ-013 cfg_chi, cfg_cho  in  CHN_WIDTH  input/output channel groups, nonzero.
REQ-014 cfg_stride  in  1  0 = stride 1, 1 = stride 2.
REQ-015 cfg_k3  in  1  1 = 3x3 kernel, 0 = 1x1 kernel.
REQ-016 cfg_ifm_size  in  FMS_WIDTH  padded input size, square.
REQ-017 ifm_read  out  ROWS  per-row input fetch strobe.
REQ-018 wgt_read  out  1  weight fetch strobe.
REQ-019 pvalid  out  ROWS  per-row partial-sum valid.
REQ-020 ic_done, oc_done, tile_done, conv_done  out  1 each  completion pulses.
REQ-021 busy  out  1  high when state is not IDLE.

Function
REQ-022 Config SHALL be latched on accepted start and held until the return to IDLE.
REQ-023 Output size SHALL be: K = 3 if cfg_k3 else 1, S = cfg_stride+1, ofm = ((ifm-K)>>(S-1))+1, computed in FMS_WIDTH bits.
REQ-024 Tiling SHALL be: OPT = TILE_LEN/S output columns per column tile, ROWS output rows per row tile; tile counts = ceil(ofm/OPT) and ceil(ofm/ROWS); rem_cols = ofm mod OPT, rem_rows = ofm mod ROWS, where 0 means the last tile is full.
REQ-025 FSM states SHALL be IDLE, FLUSH and CALC:
- IDLE to FLUSH on start.
- FLUSH to CALC after FLUSH_LAT cycles.
- CALC to FLUSH on ic_done unless conv_done.
- CALC to IDLE on conv_done.
REQ-026 In CALC with stall=0, step counter pc_col SHALL advance 0 to TILE_LEN-1; ic_done SHALL pulse on the step where pc_col = TILE_LEN-1, and pc_col SHALL then clear.
REQ-027 The ic pass counter SHALL count 0 to (cfg_chi<<CHN_OFT_WIDTH)-1; oc_done = ic_done on the last ic pass, and the ic counter SHALL wrap.
REQ-028 The oc counter SHALL count 0 to (cfg_cho<<CHN_OFT_WIDTH)-1; tile_done = oc_done on the last oc pass.
REQ-029 tile_done SHALL advance the column tile; the last column tile SHALL wrap to 0 and advance the row tile; conv_done = tile_done on the last column and last row tile.
REQ-030 wgt_read SHALL be high on the start-accept cycle, on every ic_done without conv_done, and on the first two FLUSH cycles.
REQ-031 ifm_read SHALL equal {ROWS{FLUSH or CALC}} AND the row mask.
REQ-032 The row mask SHALL be (1<<rem_rows)-1 in the last row tile when rem_rows != 0, else all ones.
REQ-033 A step SHALL be productive when S = 1, or when S = 2 and pc_col[0] = 1.
REQ-034 A productive step SHALL be column-masked when in the last column tile, rem_cols != 0 and (pc_col>>(S-1)) >= rem_cols.
REQ-035 pvalid SHALL equal the productive, unmasked step delayed by PV_LAT, ANDed with the row mask of the same step.
REQ-036 While stall=1, all counters, FSM, FLUSH timer and delay pipelines SHALL hold, and ifm_read, wgt_read, pvalid and the done pulses SHALL be 0.
REQ-037 abort SHALL force IDLE, clear all counters and pipelines and suppress all outputs next cycle; abort SHALL have priority over stall and start.
REQ-038 start while busy SHALL be ignored.

Reset
REQ-039 On rstn low, the FSM SHALL be IDLE, all counters and pipelines zero, and every output 0.
REQ-040 Reset mid-operation SHALL abandon the run; no done pulse SHALL follow it.

Verification
REQ-041 ifm=18, k3, S=1, CHN_OFT_WIDTH=1, chi=cho=1, start at cycle 0 -> ic_done at cycles 21n for n=1..8, conv_done at 168, busy low at 169.
REQ-042 ifm=13, k3, S=1 -> ofm 11; steps pc_col 11..15 give no pvalid; second row tile pvalid = 8'b00000111.
REQ-043 ifm=19, k3, S=2 -> ofm 9, 2 column tiles; 8 pvalid pulses per full pass; last column tile pvalid only from step pc_col=1; last row tile mask = 8'b00000001.
REQ-044 stall held 4 cycles mid-CALC -> outputs 0 throughout; ic_done and conv_done each delayed exactly 4 cycles.
REQ-045 abort in CALC, then start -> busy low for 1 cycle, no done pulse; new run timing identical to REQ-041.
REQ-046 rstn low for 1 cycle during FLUSH -> all outputs 0 immediately (asynchronous); FSM IDLE.
